// File: rtl/sync_conditioner.sv
// sync_conditioner: synchronise and deglitch CPS2 syncs, measure line/frame timing, track lock.
module sync_conditioner #(
  parameter int          FILT_LEN    = 4,
  parameter logic [11:0] H_MIN       = 12'd1500,
  parameter logic [11:0] H_MAX       = 12'd1700,
  parameter logic [9:0]  V_MIN       = 10'd256,
  parameter logic [9:0]  V_MAX       = 10'd270,
  parameter int          LOCK_FRAMES = 3
) (
  input  logic        clk25,
  input  logic        reset_n,
  input  logic        HSYNC_raw,
  input  logic        VSYNC_raw,
  output logic        HSYNC_out,
  output logic        VSYNC_out,
  output logic [11:0] h_period,
  output logic [9:0]  lines_per_frame,
  output logic        frame_start,
  output logic        locked
);
  localparam int FW = $clog2(FILT_LEN + 1);
  localparam logic [FW-1:0] FL1 = FW'(FILT_LEN - 1);
  localparam logic [3:0] LF = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {UNLOCKED, CHECK, LOCKED} state_t;

  // index 0 is HSYNC, index 1 is VSYNC
  logic [1:0] s1_q, s2_q, f_q, f_d;
  logic [1:0][FW-1:0] fc_q, fc_d;
  logic [11:0] hcnt_q, hcnt_d, h_period_q, h_period_d;
  logic [9:0] lcnt_q, lcnt_d, lpf_q, lpf_d, ref_q, ref_d;
  logic [3:0] match_q, match_d;
  logic h_valid_q, v_valid_q, frame_ok_q, frame_ok_d, frame_start_q;
  logic hs_fall, vs_fall, h_to, h_bad, v_to, v_in, frame_valid;
  state_t state_q, state_d;

  // filtered level flips only after the synchronised input has disagreed for FILT_LEN cycles
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      fc_d[i] = (s2_q[i] != f_q[i] && fc_q[i] != FL1) ? fc_q[i] + 1'b1 : '0;
      f_d[i] = (s2_q[i] != f_q[i] && fc_q[i] == FL1) ? ~f_q[i] : f_q[i];
    end
  end

  // fall strobes are taken from the next filtered level so measurement updates with the output edge
  assign hs_fall = f_q[0] & ~f_d[0];
  assign vs_fall = f_q[1] & ~f_d[1];
  assign h_to = &hcnt_q;
  assign h_bad = hs_fall & h_valid_q & (hcnt_q < H_MIN | hcnt_q > H_MAX);
  assign v_to = lcnt_q > V_MAX;
  assign v_in = lcnt_q >= V_MIN & ~v_to;
  assign frame_valid = vs_fall & v_valid_q & frame_ok_q & ~h_bad & ~h_to & v_in;

  assign hcnt_d = hs_fall ? 12'd1 : hcnt_q + {11'd0, ~h_to};
  assign h_period_d = (hs_fall & h_valid_q) ? hcnt_q : h_period_q;
  // a line edge coinciding with the frame edge is counted as line 1 of the new frame
  assign lcnt_d = vs_fall ? {9'd0, hs_fall} : lcnt_q + {9'd0, hs_fall & ~&lcnt_q};
  assign lpf_d = (vs_fall & v_valid_q) ? lcnt_q : lpf_q;
  assign frame_ok_d = vs_fall | (frame_ok_q & ~h_bad & ~h_to);

  // lock tracking: consecutive valid frames with identical line count
  always_comb begin
    state_d = state_q;
    ref_d = ref_q;
    match_d = match_q;
    case (state_q)
      UNLOCKED: if (frame_valid) begin
        ref_d = lcnt_q;
        match_d = 4'd1;
        state_d = (LF <= 4'd1) ? LOCKED : CHECK;
      end
      CHECK: if (h_to | v_to | (vs_fall & ~frame_valid)) state_d = UNLOCKED;
      else if (frame_valid && lcnt_q == ref_q) begin
        match_d = match_q + 4'd1;
        state_d = (match_d >= LF) ? LOCKED : CHECK;
      end else if (frame_valid) begin
        ref_d = lcnt_q;
        match_d = 4'd1;
      end
      LOCKED: if (h_bad | h_to | v_to | (vs_fall & ~frame_valid)) state_d = UNLOCKED;
      else if (vs_fall && lcnt_q != ref_q) begin
        ref_d = lcnt_q;
        match_d = 4'd1;
        state_d = CHECK;
      end
      default: state_d = UNLOCKED;
    endcase
  end

  // all state in the clk25 domain, cleared asynchronously
  always_ff @(posedge clk25 or negedge reset_n) begin
    if (!reset_n) begin
      s1_q <= 2'b11;
      s2_q <= 2'b11;
      f_q <= 2'b11;
      fc_q <= '0;
      hcnt_q <= '0;
      h_period_q <= '0;
      lcnt_q <= '0;
      lpf_q <= '0;
      ref_q <= '0;
      match_q <= '0;
      h_valid_q <= 1'b0;
      v_valid_q <= 1'b0;
      frame_ok_q <= 1'b0;
      frame_start_q <= 1'b0;
      state_q <= UNLOCKED;
    end else begin
      s1_q <= {VSYNC_raw, HSYNC_raw};
      s2_q <= s1_q;
      f_q <= f_d;
      fc_q <= fc_d;
      hcnt_q <= hcnt_d;
      h_period_q <= h_period_d;
      lcnt_q <= lcnt_d;
      lpf_q <= lpf_d;
      ref_q <= ref_d;
      match_q <= match_d;
      h_valid_q <= h_valid_q | hs_fall;
      v_valid_q <= v_valid_q | vs_fall;
      frame_ok_q <= frame_ok_d;
      frame_start_q <= vs_fall;
      state_q <= state_d;
    end
  end

  assign HSYNC_out = f_q[0];
  assign VSYNC_out = f_q[1];
  assign h_period = h_period_q;
  assign lines_per_frame = lpf_q;
  assign frame_start = frame_start_q;
  assign locked = state_q == LOCKED;
endmodule

// File: tb/tb_sync_conditioner.sv
// tb_sync_conditioner: table-driven frame checks plus glitch, sync-loss and mid-frame reset sequences.
module tb_sync_conditioner;
  // timing scaled down: 50-cycle lines (hsync low 6), 10-line frames (vsync low 2 lines)
  logic clk = 1'b0;
  logic reset_n, HSYNC_raw, VSYNC_raw;
  logic HSYNC_out, VSYNC_out, frame_start, locked;
  logic [11:0] h_period;
  logic [9:0] lines_per_frame;
  int total = 0;
  int bad = 0;
  int hs_falls = 0;
  int vs_falls = 0;
  int fs_cnt = 0;
  logic hs_prev = 1'b1;
  logic vs_prev = 1'b1;

  typedef struct {
    int nl;
    int per;
    int pre;
    int post;
    int h;
    int l;
  } row_t;
  row_t rows [26];

  sync_conditioner #(
    .FILT_LEN(4), .H_MIN(12'd45), .H_MAX(12'd55), .V_MIN(10'd8), .V_MAX(10'd12), .LOCK_FRAMES(3)
  ) dut (
    .clk25(clk), .reset_n(reset_n), .HSYNC_raw(HSYNC_raw), .VSYNC_raw(VSYNC_raw),
    .HSYNC_out(HSYNC_out), .VSYNC_out(VSYNC_out), .h_period(h_period),
    .lines_per_frame(lines_per_frame), .frame_start(frame_start), .locked(locked)
  );

  always #5 clk = ~clk;

  // edge and pulse counters sampled on the falling clock edge
  always @(negedge clk) begin
    if (hs_prev && !HSYNC_out) hs_falls++;
    if (vs_prev && !VSYNC_out) vs_falls++;
    if (frame_start) fs_cnt++;
    hs_prev = HSYNC_out;
    vs_prev = VSYNC_out;
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(input logic h, input logic v);
    HSYNC_raw = h;
    VSYNC_raw = v;
    @(posedge clk);
    #1;
  endtask

  task automatic run_row(input int r);
    for (int ln = 0; ln < rows[r].nl; ln++)
      for (int c = 0; c < rows[r].per; c++) begin
        if (ln == 0 && c == 5) begin
          chk($sformatf("r%0d_pre_lock", r), int'(locked), rows[r].pre);
          chk($sformatf("r%0d_vs_pre", r), int'(VSYNC_out), 1);
          chk($sformatf("r%0d_hs_pre", r), int'(HSYNC_out), 1);
          chk($sformatf("r%0d_fs_pre", r), int'(frame_start), 0);
        end
        if (ln == 0 && c == 6) begin
          chk($sformatf("r%0d_vs_edge", r), int'(VSYNC_out), 0);
          chk($sformatf("r%0d_hs_edge", r), int'(HSYNC_out), 0);
          chk($sformatf("r%0d_fs_pulse", r), int'(frame_start), 1);
        end
        if (ln == 0 && c == 7) chk($sformatf("r%0d_fs_end", r), int'(frame_start), 0);
        if (ln == 0 && c == 8) begin
          chk($sformatf("r%0d_lock", r), int'(locked), rows[r].post);
          chk($sformatf("r%0d_h_period", r), int'(h_period), rows[r].h);
          if (rows[r].l >= 0) chk($sformatf("r%0d_lines", r), int'(lines_per_frame), rows[r].l);
        end
        step(c >= 6, ln >= 2);
      end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_hs"}, int'(HSYNC_out), 1);
    chk({tag, "_vs"}, int'(VSYNC_out), 1);
    chk({tag, "_h_period"}, int'(h_period), 0);
    chk({tag, "_lines"}, int'(lines_per_frame), 0);
    chk({tag, "_fs"}, int'(frame_start), 0);
    chk({tag, "_lock"}, int'(locked), 0);
  endtask

  initial begin
    int hf0, vf0, fs0;
    rows[0] = '{10, 50, 0, 0, 0, 0};
    rows[1] = '{10, 50, 0, 0, 50, 10};
    rows[2] = '{10, 50, 0, 0, 50, 10};
    rows[3] = '{10, 50, 0, 1, 50, 10};
    rows[4] = '{10, 50, 1, 1, 50, 10};
    rows[5] = '{10, 50, 1, 1, 50, 10};
    rows[6] = '{11, 50, 1, 1, 50, 10};
    rows[7] = '{11, 50, 1, 0, 50, 11};
    rows[8] = '{11, 50, 0, 0, 50, 11};
    rows[9] = '{11, 50, 0, 1, 50, 11};
    rows[10] = '{11, 50, 0, 0, 4095, -1};
    rows[11] = '{11, 50, 0, 0, 50, 11};
    rows[12] = '{11, 50, 0, 0, 50, 11};
    rows[13] = '{11, 50, 0, 1, 50, 11};
    rows[14] = '{10, 40, 1, 1, 50, 11};
    rows[15] = '{10, 40, 0, 0, 40, 10};
    rows[16] = '{10, 40, 0, 0, 40, 10};
    rows[17] = '{10, 50, 0, 0, 40, 10};
    rows[18] = '{10, 50, 0, 0, 50, 10};
    rows[19] = '{10, 50, 0, 0, 50, 10};
    rows[20] = '{10, 50, 0, 1, 50, 10};
    for (int i = 0; i < 5; i++) rows[21 + i] = rows[i];
    reset_n = 1'b0;
    HSYNC_raw = 1'b1;
    VSYNC_raw = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("reset");
    reset_n = 1'b1;
    for (int r = 0; r < 5; r++) run_row(r);
    chk("frame_start_count", fs_cnt, 5);
    hf0 = hs_falls;
    vf0 = vs_falls;
    fs0 = fs_cnt;
    for (int ln = 0; ln < 10; ln++)
      for (int c = 0; c < 50; c++)
        step(!(c < 6 || (ln == 4 && c >= 20 && c < 23)), !(ln < 2 || (ln == 5 && c >= 30 && c < 33)));
    chk("glitch_hs_falls", hs_falls - hf0, 10);
    chk("glitch_vs_falls", vs_falls - vf0, 1);
    chk("glitch_fs", fs_cnt - fs0, 1);
    chk("glitch_h_period", int'(h_period), 50);
    chk("glitch_lock", int'(locked), 1);
    for (int r = 5; r < 10; r++) run_row(r);
    for (int c = 0; c < 4110; c++) begin
      if (c == 4100) chk("hstop_lock_before", int'(locked), 1);
      if (c == 4101) chk("hstop_lock_after", int'(locked), 0);
      step(c >= 6, c >= 100);
    end
    for (int r = 10; r < 21; r++) run_row(r);
    for (int n = 0; n < 108; n++) step(n % 50 >= 6, n >= 100);
    chk("midreset_hs_before", int'(HSYNC_out), 0);
    chk("midreset_lock_before", int'(locked), 1);
    reset_n = 1'b0;
    #1;
    chk_reset("midreset");
    HSYNC_raw = 1'b1;
    VSYNC_raw = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int r = 21; r < 26; r++) run_row(r);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
